div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_pkg.sv | 34 +++
 rtl/cla_add_sub.sv | 37 +++
 rtl/div_unit.sv | 153 +++++++++++++++
 tb/tb_div_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared op encodings, FSM states and cycle count for the iterative divider
package div_pkg;

  localparam int DIV_WIDTH  = 32;
  // One restoring step per result bit.
  localparam int DIV_CYCLES = DIV_WIDTH;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } div_state_e;

  // Step count for an arbitrary operand width (the parameterised top uses this).
  function automatic int div_cycles(input int width);
    return width;
  endfunction

  function automatic logic op_is_signed(input div_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/cla_add_sub.sv
// rtl/cla_add_sub.sv - generate/propagate adder-subtractor shared across execution units
//
// Ports:
//   a, b      : WIDTH-bit operands
//   funct7_5  : 1 = a - b (b inverted, carry-in 1), 0 = a + b
//   sum       : WIDTH-bit result
//   carry_out : carry from the top bit; for subtraction 1 means a >= b (no borrow)
module CLA_ADD_SUB #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             funct7_5,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;

  assign b_eff = b ^ {WIDTH{funct7_5}};
  assign gen   = a & b_eff;
  assign prop  = a ^ b_eff;

  always_comb begin
    logic [WIDTH:0] carry;
    carry    = '0;
    carry[0] = funct7_5;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
    sum       = prop ^ carry[WIDTH-1:0];
    carry_out = carry[WIDTH];
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring divider for DIV/DIVU/REM/REMU
//
// Ports:
//   CLK, rst   : clock, asynchronous active-high reset
//   En         : start request, honoured only while idle and not in the done cycle
//   rs_1, rs_2 : dividend, divisor
//   funct3     : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   result     : quotient or remainder, held until the next completed operation
//   busy       : high from the cycle after acceptance through the done cycle
//   done       : one-cycle pulse, result valid
//   div_zero   : set with done when the divisor was zero, cleared on the next start
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             En,
  input  logic [WIDTH-1:0] rs_1,
  input  logic [WIDTH-1:0] rs_2,
  input  logic [1:0]       funct3,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int               CYCLES   = div_cycles(WIDTH);
  localparam int               CNT_W    = $clog2(CYCLES);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(CYCLES - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  div_op_e          op_in, op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] quo_q, rem_q, divisor_q;
  logic             neg_quo_q, neg_rem_q, dz_q;

  logic             in_signed, accept, dz_in, ovf_in;
  logic [WIDTH:0]   rs1_ext, rs2_ext, rs1_mag, rs2_mag;
  logic [WIDTH:0]   trial_a, trial_b, trial;
  logic             fits;
  logic [WIDTH-1:0] quo_fix, rem_fix, fin_result;
  logic             unused_bits;

  assign op_in     = div_op_e'(funct3);
  assign in_signed = op_is_signed(op_in);
  assign accept    = (state_q == S_IDLE) && En && !done;
  assign dz_in     = (rs_2 == '0);
  assign ovf_in    = in_signed && (rs_1 == MOST_NEG) && (rs_2 == '1);

  // Magnitudes in WIDTH+1 bits so |most negative| is representable.
  assign rs1_ext = {in_signed & rs_1[WIDTH-1], rs_1};
  assign rs2_ext = {in_signed & rs_2[WIDTH-1], rs_2};
  assign rs1_mag = rs1_ext[WIDTH] ? (~rs1_ext + (WIDTH+1)'(1)) : rs1_ext;
  assign rs2_mag = rs2_ext[WIDTH] ? (~rs2_ext + (WIDTH+1)'(1)) : rs2_ext;

  // Partial remainder shifted left with the next dividend bit brought in.
  assign trial_a = {rem_q, quo_q[WIDTH-1]};
  assign trial_b = {1'b0, divisor_q};

  CLA_ADD_SUB #(
    .WIDTH (WIDTH + 1)
  ) u_trial_sub (
    .a         (trial_a),
    .b         (trial_b),
    .funct7_5  (1'b1),
    .sum       (trial),
    .carry_out (fits)
  );

  // Top bits are always zero here: magnitudes fit WIDTH bits, and a kept
  // trial difference is below the divisor.
  assign unused_bits = ^{trial[WIDTH], rs1_mag[WIDTH], rs2_mag[WIDTH]};

  assign quo_fix    = neg_quo_q ? (~quo_q + WIDTH'(1)) : quo_q;
  assign rem_fix    = neg_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;
  assign fin_result = op_is_rem(op_q) ? rem_fix : quo_fix;

  assign busy = (state_q != S_IDLE) || done;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (dz_in || ovf_in) ? S_FIN : S_CALC;
      S_CALC: if (cnt_q == LAST) state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      op_q      <= OP_DIV;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      result    <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q      <= op_in;
            cnt_q     <= '0;
            dz_q      <= dz_in;
            div_zero  <= 1'b0;
            divisor_q <= rs2_mag[WIDTH-1:0];
            if (dz_in || ovf_in) begin
              // Final values preloaded; FIN only selects between them.
              quo_q     <= dz_in ? '1 : rs_1;
              rem_q     <= dz_in ? rs_1 : '0;
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
            end else begin
              quo_q     <= rs1_mag[WIDTH-1:0];
              rem_q     <= '0;
              neg_quo_q <= in_signed & (rs_1[WIDTH-1] ^ rs_2[WIDTH-1]);
              neg_rem_q <= in_signed & rs_1[WIDTH-1];
            end
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          quo_q <= {quo_q[WIDTH-2:0], fits};
          rem_q <= fits ? trial[WIDTH-1:0] : trial_a[WIDTH-1:0];
        end
        S_FIN: begin
          result   <= fin_result;
          done     <= 1'b1;
          div_zero <= dz_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit (vector table, scoreboard, corner sequences)
module tb_div_unit;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        dz;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        dz;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] rs_1, rs_2;
  logic [1:0]  funct3;
  logic [31:0] result;
  logic        busy, done, div_zero;

  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[16];

  div_unit #(.WIDTH(32)) dut (
    .CLK      (clk),
    .rst      (rst),
    .En       (en),
    .rs_1     (rs_1),
    .rs_2     (rs_2),
    .funct3   (funct3),
    .result   (result),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    e.dz = 1'b0;
    if (b == 32'd0) begin
      e.dz  = 1'b1;
      e.res = op[1] ? a : 32'hFFFF_FFFF;
    end else if (op[0] == 1'b0) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.res = op[1] ? 32'd0 : a;
      else e.res = op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end else begin
      e.res = op[1] ? (a % b) : (a / b);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done=1, required no pending operation");
      end else begin
        mon_e = sb_q.pop_front();
        check("result", result, mon_e.res);
        check("div_zero", {31'd0, div_zero}, {31'd0, mon_e.dz});
        check("busy_at_done", {31'd0, busy}, 32'd1);
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy) timeout("wait_idle");
  endtask

  // Starts one op from idle; lat counts edges from the accepting edge (1) to
  // the edge after which done is seen.
  task automatic run_vec(input vec_t v);
    exp_t e;
    int   lat;
    wait_idle();
    en     = 1'b1;
    funct3 = v.op;
    rs_1   = v.a;
    rs_2   = v.b;
    e.res  = v.res;
    e.dz   = v.dz;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    en  = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) timeout("run_vec_done");
    else if (v.lat != 0) check("latency", 32'(lat), 32'(v.lat));
  endtask

  initial begin
    int   lat;
    int   ndone;
    int   low;
    int   t;
    logic prev_busy;
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;
    vec_t hv;

    vecs[0]  = '{2'b00, 32'd20,         32'd3,         32'd6,         1'b0, 34};
    vecs[1]  = '{2'b10, 32'd20,         32'd3,         32'd2,         1'b0, 34};
    vecs[2]  = '{2'b00, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 1'b0, 34};
    vecs[3]  = '{2'b10, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 1'b0, 34};
    vecs[4]  = '{2'b01, 32'hFFFF_FFFF,  32'd2,         32'h7FFF_FFFF, 1'b0, 34};
    vecs[5]  = '{2'b11, 32'hFFFF_FFFF,  32'd2,         32'd1,         1'b0, 34};
    vecs[6]  = '{2'b00, 32'd7,          32'd0,         32'hFFFF_FFFF, 1'b1, 2};
    vecs[7]  = '{2'b11, 32'd7,          32'd0,         32'd7,         1'b1, 2};
    vecs[8]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 2};
    vecs[9]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b0, 2};
    vecs[10] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b0, 34};
    vecs[11] = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 34};
    vecs[12] = '{2'b00, 32'd20,         32'hFFFF_FFFD, 32'hFFFF_FFFA, 1'b0, 34};
    vecs[13] = '{2'b10, 32'd20,         32'hFFFF_FFFD, 32'd2,         1'b0, 34};
    vecs[14] = '{2'b10, 32'hFFFF_FFEC,  32'd0,         32'hFFFF_FFEC, 1'b1, 2};
    vecs[15] = '{2'b00, 32'h8000_0000,  32'd2,         32'hC000_0000, 1'b0, 34};

    rst    = 1'b1;
    en     = 1'b0;
    rs_1   = '0;
    rs_2   = '0;
    funct3 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", result, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_div_zero", {31'd0, div_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Inputs and En disturbed mid-calculation must not affect the result.
    wait_idle();
    en = 1'b1; funct3 = 2'b00; rs_1 = 32'd100; rs_2 = 32'd7;
    sb_q.push_back('{32'd14, 1'b0});
    @(posedge clk);
    #1;
    en  = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat >= 4 && lat <= 12) begin
        en     = 1'($urandom_range(0, 1));
        rs_1   = $urandom;
        rs_2   = $urandom;
        funct3 = 2'($urandom_range(0, 3));
      end else begin
        en = 1'b0;
      end
    end
    check("disturbed_latency", 32'(lat), 32'd34);

    // Reset in the middle of a calculation aborts it without a done pulse.
    wait_idle();
    en = 1'b1; funct3 = 2'b00; rs_1 = 32'd100; rs_2 = 32'd7;
    sb_q.push_back('{32'd14, 1'b0});
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    sb_q.delete();
    #1;
    check("abort_result", result, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_div_zero", {31'd0, div_zero}, 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    hv = '{2'b00, 32'd9, 32'd3, 32'd3, 1'b0, 34};
    run_vec(hv);

    // Back-to-back random operations with En held high.
    wait_idle();
    r_op = 2'($urandom_range(0, 3));
    r_a  = $urandom;
    r_b  = $urandom;
    en = 1'b1; funct3 = r_op; rs_1 = r_a; rs_2 = r_b;
    sb_q.push_back(model(r_op, r_a, r_b));
    prev_busy = 1'b0;
    low       = 0;
    for (int i = 0; i < 200; i++) begin
      t = 0;
      forever begin
        @(posedge clk);
        #1;
        t++;
        if (busy && !prev_busy) break;
        if (!busy) low++;
        prev_busy = busy;
        if (t > 100) break;
      end
      if (t > 100) begin
        timeout("b2b_accept");
        break;
      end
      prev_busy = busy;
      if (i > 0) check("b2b_gap", 32'(low), 32'd1);
      low = 0;
      if (i < 199) begin
        r_op = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 7))
          0:       r_a = 32'h8000_0000;
          1:       r_a = $urandom_range(0, 1000);
          default: r_a = $urandom;
        endcase
        case ($urandom_range(0, 7))
          0:       r_b = 32'd0;
          1:       r_b = 32'hFFFF_FFFF;
          2, 3:    r_b = $urandom_range(1, 20);
          default: r_b = $urandom;
        endcase
        funct3 = r_op; rs_1 = r_a; rs_2 = r_b;
        sb_q.push_back(model(r_op, r_a, r_b));
      end else begin
        en = 1'b0;
      end
    end
    en = 1'b0;

    t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
